// File: rtl/alu_trace_recorder.sv
// Snoops the mips_alu operand/result bus and buffers 105-bit trace records in a circular FIFO.
// Optional build macro ALU_TRACE_CHECK_EN adds a reference ALU model that flags mismatching records.

module alu_trace_recorder #(
    parameter int DEPTH        = 16,
    parameter bit STOP_ON_FULL = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     cap_valid,
    input  logic [2:0]               F,
    input  logic [31:0]              A,
    input  logic [31:0]              B,
    input  logic [31:0]              Y,
    input  logic                     Z,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [104:0]             rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     capturing,
    output logic [15:0]              drop_count,
    output logic [15:0]              mismatch_count
);

    // state      | meaning
    // ST_IDLE    | after reset, nothing captured, reads still allowed
    // ST_CAPTURE | valid ALU transactions are recorded into the buffer
    // ST_DONE    | capture ended by stop or by a full buffer; host drains

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t          state;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count_q;
    logic [15:0]     drop_q;
    logic [104:0]    mem [DEPTH];

    logic            rd_fire;
    logic            wr_req;
    logic            wr_fire;
    logic            drop_evt;
    logic            chk_fail;
    logic            fills_up;
    logic [104:0]    wr_record;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign rd_valid  = !empty;
    assign rd_data   = mem[rd_ptr];
    assign count     = count_q;
    assign drop_count = drop_q;

    // A start edge flushes the buffer, so neither port may move on that cycle.
    assign rd_fire   = rd_valid && rd_ready && !start;
    assign wr_req    = (state == ST_CAPTURE) && cap_valid && !stop && !start;
    assign wr_fire   = wr_req && (!full || rd_fire);
    assign drop_evt  = wr_req && !wr_fire && !STOP_ON_FULL;
    assign fills_up  = wr_fire && !rd_fire && (count_q == CW'(DEPTH - 1));

    assign wr_record = {chk_fail, 1'b0, F, A, B, Y, 3'b000, Z};

`ifdef ALU_TRACE_CHECK_EN
    logic [31:0] diff;
    logic [31:0] exp_y;
    logic        exp_z;
    logic [15:0] mismatch_q;

    assign diff = A - B;

    always_comb begin
        exp_y = '0;
        case (F)
            3'b000:  exp_y = A & B;
            3'b001:  exp_y = A | B;
            3'b010:  exp_y = A + B;
            3'b011:  exp_y = '0;
            3'b100:  exp_y = A & ~B;
            3'b101:  exp_y = A | ~B;
            3'b110:  exp_y = diff;
            default: exp_y = {31'd0, diff[31]};
        endcase
    end

    assign exp_z    = (exp_y == '0);
    assign chk_fail = (exp_y != Y) || (exp_z != Z);

    // Only records that actually land in the buffer are counted.
    always_ff @(posedge clk) begin
        if (reset || start) begin
            mismatch_q <= '0;
        end else if (wr_fire && chk_fail && (mismatch_q != 16'hFFFF)) begin
            mismatch_q <= mismatch_q + 16'd1;
        end
    end

    assign mismatch_count = mismatch_q;
`else
    assign chk_fail       = 1'b0;
    assign mismatch_count = '0;
`endif

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_ptr] <= wr_record;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            capturing <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            drop_q    <= '0;
        end else if (start) begin
            state     <= ST_CAPTURE;
            capturing <= 1'b1;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            drop_q    <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + AW'(1);
            end

            case ({wr_fire, rd_fire})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase

            if (drop_evt && (drop_q != 16'hFFFF)) begin
                drop_q <= drop_q + 16'd1;
            end

            case (state)
                ST_CAPTURE: begin
                    if (stop || (STOP_ON_FULL && fills_up)) begin
                        state     <= ST_DONE;
                        capturing <= 1'b0;
                    end
                end
                ST_IDLE, ST_DONE: begin
                    capturing <= 1'b0;
                end
                default: begin
                    state     <= ST_IDLE;
                    capturing <= 1'b0;
                end
            endcase
        end
    end

endmodule
